// File: rtl/mips_muldiv_unit_if.sv
// Control-side bundle of the MIPS multiply/divide unit: launch/move/flush
// requests towards the unit, HI/LO and status back to control.
interface mips_muldiv_unit_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic         flush;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, flush,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, flush,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU (and DIV/DIVU when MULDIV_DIV_EN is defined) engine
// owning HI/LO; one shift-add or restoring-subtract step per cycle.
module mips_muldiv_unit #(
  parameter int N = 32
) (
  input logic               clk,
  input logic               rst,
  mips_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   hi_r, lo_r;
  logic           done_r;

  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_step;
  logic [N-1:0]   opnd_b;
  logic           is_div, sign_q, sign_r, b_zero;
  logic           op_legal, accept, sgn_op;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

  function automatic logic [N-1:0] neg_if(input logic [N-1:0] v, input logic neg);
    return neg ? (~v + N'(1)) : v;
  endfunction

  function automatic logic [2*N-1:0] neg_if2(input logic [2*N-1:0] v, input logic neg);
    return neg ? (~v + (2*N)'(1)) : v;
  endfunction

`ifdef MULDIV_DIV_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = ~bus.op[1];
`endif

  assign accept = (state == IDLE) && bus.start && op_legal;
  assign sgn_op = ~bus.op[0];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (bus.flush) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MULDIV_DIV_EN
  logic [N:0]   div_t;
  logic [N-1:0] div_diff;
  logic         div_ge;
`endif

  // One iteration: multiply adds the multiplicand on the low bit then shifts
  // right; divide shifts the dividend MSB into the remainder and trial-subtracts.
  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd_b} : {(N+1){1'b0}});
    acc_step = {mul_sum, acc[N-1:1]};
`ifdef MULDIV_DIV_EN
    div_t    = {acc[2*N-1:N], acc[N-1]};
    div_ge   = div_t >= {1'b0, opnd_b};
    div_diff = div_t[N-1:0] - opnd_b;
    if (is_div)
      acc_step = div_ge ? {div_diff, acc[N-2:0], 1'b1} : {acc[2*N-2:0], 1'b0};
`endif
  end

  assign prod_fix = neg_if2(acc, sign_q);
  assign quo_fix  = neg_if(acc[N-1:0], sign_q);
  assign rem_fix  = neg_if(acc[2*N-1:N], sign_r);

  // Operand magnitudes and result signs are captured once on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc    <= {{N{1'b0}}, neg_if(bus.a, sgn_op & bus.a[N-1])};
      opnd_b <= neg_if(bus.b, sgn_op & bus.b[N-1]);
      is_div <= bus.op[1];
      sign_q <= sgn_op & (bus.a[N-1] ^ bus.b[N-1]);
      sign_r <= sgn_op & bus.op[1] & bus.a[N-1];
      b_zero <= (bus.b == '0);
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt <= CW'(N-1);
          end else begin
            if (bus.mthi) hi_r <= bus.a;
            if (bus.mtlo) lo_r <= bus.a;
          end
        end
        CALC: if (!bus.flush && cnt != '0) cnt <= cnt - CW'(1);
        FIX: begin
          if (!bus.flush) begin
            done_r <= 1'b1;
            if (is_div) begin
              hi_r <= rem_fix;
              lo_r <= b_zero ? '1 : quo_fix;
            end else begin
              {hi_r, lo_r} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV_EN
  logic dz_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         dz_r <= 1'b0;
    else if (accept)                                  dz_r <= 1'b0;
    else if (state == FIX && !bus.flush && is_div && b_zero) dz_r <= 1'b1;
  end

  assign bus.div_zero = dz_r;
`else
  assign bus.div_zero = 1'b0;
`endif

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, holding the architectural HI/LO registers. Executes MULT/MULTU, and DIV/DIVU when compiled in, over N+1 cycles using a shared shift-add/restoring-subtract engine. It sits beside the ALU in `MIPS`. Control raises `start` with the decoded operation and stalls the PC on `busy` until `done`.

## Interface
- `N`, default 32: operand width, equal to the package word width; must be ≥ 4 and even.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: launch request; sampled only in IDLE.
- `op`, in, 2: operation. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a`, in, N: rs operand, multiplicand or dividend; also MTHI/MTLO write data.
- `b`, in, N: rt operand, multiplier or divisor.
- `mthi`, in, 1: write `a` into HI; honoured in IDLE only.
- `mtlo`, in, 1: write `a` into LO; honoured in IDLE only.
- `flush`, in, 1: abort the operation in flight.
- `hi`, out, N: HI register.
- `lo`, out, N: LO register.
- `busy`, out, 1: high while an operation is in progress.
- `done`, out, 1: one-cycle pulse; HI/LO hold the new result.
- `div_zero`, out, 1: sticky divide-by-zero flag; cleared by the next accepted `start`.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - CALC: N iterations, down-counter of width clog2(N).
  - FIX: sign correction and HI/LO writeback.
- IDLE → CALC on `start` with a legal `op`.
  - Latch |a| and |b|; signed ops use two's-complement absolute values in N bits, so -2^(N-1) maps to unsigned 2^(N-1).
  - Latch the result sign: a[N-1]^b[N-1] for MULT, a[N-1]^b[N-1] for the DIV quotient, a[N-1] for the DIV remainder. Unsigned ops have sign 0.
- CALC, multiply: one shift-add step per cycle into a 2N-bit accumulator.
- CALC, divide: one restoring subtract-shift step per cycle. Quotient goes to LO, remainder to HI.
- CALC → FIX when the counter reaches 0.
- FIX:
  - Negate the product (2N bits) or the quotient/remainder (N bits each) as the latched signs require.
  - Write HI/LO; go to IDLE; pulse `done`.
- MULT/MULTU result: HI = upper N bits, LO = lower N bits of the 2N-bit product.
- Divide by zero (b==0):
  - Full latency still runs.
  - Result HI = a, LO = all ones.
  - `div_zero` is set in FIX.
- Overflow case -2^(N-1) / -1: LO = 0x8000_0000 (N=32), HI = 0. No flag.
- `start` while `busy`: ignored. Control is responsible for not issuing it.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins; the moves are dropped.
- `mthi` and `mtlo` together: both registers are written.
- `flush` in CALC/FIX: go to IDLE next edge. HI/LO unchanged, no `done`, `div_zero` unchanged. `flush` in IDLE has no effect.
- Operands are latched on acceptance; later changes on `a`/`b` do not affect the result.

## Timing
- Reset (`rst`=0): state IDLE, counter 0, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0. Reset takes effect immediately, including mid-operation.
- `busy` is high from the cycle after the accepting edge until the FIX edge, i.e. N+1 cycles.
- Latency: `start` sampled on edge E; the N CALC iterations are on edges E+1 … E+N; FIX on edge E+N+1.
  - `done`=1 and the new HI/LO are visible in the cycle after edge E+N+1.
  - `busy`=0 in that same cycle.
  - For N=32: 33 edges from accept to result.
- A new `start` is accepted in the same cycle `done` is high, giving back-to-back throughput of one op every N+2 cycles.
- MTHI/MTLO: the register updates on the sampling edge; no `done` pulse.
- `hi`/`lo` are driven directly from registers; there is no combinational path from inputs.

## Configuration
- `MULDIV_DIV_EN` defined:
  - DIV/DIVU are implemented as above.
  - `div_zero` is functional.
- `MULDIV_DIV_EN` undefined:
  - The divide datapath is removed.
  - `start` with op[1]=1 is ignored: stays in IDLE, no `busy`, no `done`, HI/LO unchanged.
  - `div_zero` is tied to 0.

## Test plan
- Reset mid-CALC after MULTU a=0xFFFF_FFFF, b=2 → outputs zero immediately. A repeated op then gives HI=0x0000_0001, LO=0xFFFF_FFFE, `done` exactly 33 cycles after accept.
- MULT a=-3 (0xFFFF_FFFD), b=7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. MULT with a=0x8000_0000, b=0x8000_0000 → HI=0x4000_0000, LO=0.
- DIV a=-7, b=2 → LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU a=100, b=7 → LO=14, HI=2.
- DIV a=5, b=0 → HI=5, LO=0xFFFF_FFFF, `div_zero`=1. A following MULTU start clears `div_zero`.
- `flush` on the 10th CALC cycle with HI preloaded to 0x1234 via `mthi` → no `done`, HI=0x1234. `mthi` and `start` asserted mid-`busy` → both ignored.
- Build without `MULDIV_DIV_EN`: DIVU start → `busy` stays 0, no `done`. MULTU 6×7 → LO=42.
